customer_deposit: RTL and testbench
===================================

# customer_deposit

Customer-side front end of the vending machine. It accepts coins into a per-transaction credit and validates item selections against fixed prices. It moves the price of each completed sale into the machine accumulator, then returns change through a two-phase handshake. Its `machineAcc` output is the accumulator that the owner-retrieve logic reads and drains in owner mode (`mode`=1).

## Interface
- `PRICE0`, default 3, price of item 0 (5-bit)
- `PRICE1`, default 5, price of item 1
- `PRICE2`, default 7, price of item 2
- `PRICE3`, default 12, price of item 3
- `MAX_CREDIT`, default 31, credit ceiling (≤31)
- `ACC_MAX`, default 31, accumulator ceiling (≤31)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = customer mode, 1 = owner mode
- `coin_valid`  in  1  one-cycle coin strobe
- `coin`  in  2  coin code: 00=1, 01=2, 10=5, 11=10
- `sel_valid`  in  1  one-cycle selection strobe
- `sel`  in  2  item index 0..3
- `cancel`  in  1  one-cycle request to abort and refund credit
- `dispense_ack`  in  1  dispenser has delivered the item
- `change_ack`  in  1  payout unit has taken the change
- `retrieve`  in  1  owner drain strobe; clears accumulator
- `machineAcc`  out  5  accumulated sales revenue
- `credit`  out  5  current customer credit
- `dispense`  out  1  item request, held until `dispense_ack`
- `item`  out  2  item index being dispensed
- `change_valid`  out  1  change offered, held until `change_ack`
- `change`  out  5  change amount
- `coin_reject`  out  1  one-cycle pulse; coin returned, not credited
- `sale_refused`  out  1  one-cycle pulse; selection rejected

## Operation
- States: IDLE, COLLECT, VEND, CHANGE. All outputs are registered.
- Reset values: state IDLE; `machineAcc`, `credit`, `item` and `change` are 0; all strobes and flags are 0. Reset overrides everything, including mid-VEND and mid-CHANGE, and discards the pending credit and change.

IDLE:
- With `mode`=0, `coin_valid` sets `credit` to the coin value and moves to COLLECT.
- With `mode`=1, coins pulse `coin_reject` and selections pulse `sale_refused`.
- `retrieve` with `mode`=1 clears `machineAcc` to 0. It is ignored when `mode`=0.
- `sel_valid` or `cancel` with `credit`=0 is ignored.

COLLECT:
- `mode` is ignored, so a started transaction always completes.
- Priority order is `cancel`, then `sel_valid`, then `coin_valid`.
- A lower-priority coin arriving in the same cycle as a higher-priority event pulses `coin_reject`.
- A coin arriving in the same cycle as `sel_valid` is rejected, and the selection is checked against the old credit.
- Coin: if `credit` + value > `MAX_CREDIT`, pulse `coin_reject` and leave `credit` unchanged. Otherwise add the value to `credit`.
- Selection of price P:
  - If `credit` < P or `machineAcc` + P > `ACC_MAX`, pulse `sale_refused` and stay in COLLECT.
  - Otherwise, on the same edge: `machineAcc` += P, `change` ← `credit` − P, `credit` ← 0, `item` ← `sel`, `dispense` ← 1, go to VEND.
- Cancel: `change` ← `credit`, `credit` ← 0, `change_valid` ← 1, go to CHANGE.

VEND:
- `dispense` is held. Coins pulse `coin_reject`; selections and cancel are ignored.
- On `dispense_ack`, `dispense` ← 0.
  - If `change` > 0: `change_valid` ← 1, go to CHANGE.
  - Otherwise go to IDLE.

CHANGE:
- `change_valid` and `change` are held stable.
- Coins are rejected.
- On `change_ack`: `change_valid` ← 0, `change` ← 0, go to IDLE.

Arithmetic:
- All arithmetic is 6-bit internally, so comparisons cannot wrap.
- `machineAcc` never exceeds `ACC_MAX` and never wraps.

## Timing
- A coin or selection sampled at edge N shows its result (`credit`, `machineAcc`, `dispense`, and any reject/refuse pulse) after edge N. Pulses are high for exactly one cycle.
- `dispense_ack` sampled at edge M gives `dispense`=0 after edge M. `change_valid` rises after the same edge if change is due. There is no idle gap.
- `change_ack` sampled at edge K gives `change_valid`=0 after edge K. A coin is accepted from edge K+1.
- An ack already high when a state is entered is honoured at the first edge in that state, giving a minimum VEND or CHANGE dwell of one cycle.
- Acks sampled outside their state are ignored.

## Test plan
- Coins 5 then 2, then select item 1 (price 5). Required:
  - `credit` reads 5, then 7.
  - `dispense`=1 with `item`=1, and `machineAcc`=5.
  - After `dispense_ack`: `change_valid`=1 with `change`=2, held until `change_ack`, then IDLE.
- Coins 10 then 2, then select item 3. Required: `machineAcc` +12, `dispense`, no `change_valid`, return to IDLE right after `dispense_ack`.
- Three coins of 10 (`credit`=30), then coin 2. Required: `coin_reject` pulse, `credit` stays 30. Then `cancel` gives `change_valid` with `change`=30 and `machineAcc` unchanged.
- `credit`=2, select item 0. Required: `sale_refused` pulse, `credit`=2, still COLLECT. Same-cycle coin 1 with `sel_valid`: coin rejected.
- `machineAcc`=28, `credit`=5, select item 1. Required: `sale_refused`. Then with `mode`=1 in IDLE, `retrieve` gives `machineAcc`=0, and a coin in that mode pulses `coin_reject`.
- Assert `rst` for one cycle in CHANGE with `change`=4. Required: after that edge, all outputs are 0 and the state is IDLE; a following `change_ack` is ignored.

Source files
------------

// File: rtl/customer_deposit_if.sv
// customer_deposit_if: customer-side bus for the vending front end.
//   Inputs to the block: mode, coin strobe/code, selection strobe/index,
//   cancel, dispense/change acks and the owner retrieve strobe.
//   Outputs from the block: accumulator, credit, dispense/item,
//   change offer, and the coin_reject / sale_refused pulses.
//   master = stimulus side, slave = customer_deposit.
interface customer_deposit_if;
    logic       mode;
    logic       coin_valid;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       dispense_ack;
    logic       change_ack;
    logic       retrieve;
    logic [4:0] machineAcc;
    logic [4:0] credit;
    logic       dispense;
    logic [1:0] item;
    logic       change_valid;
    logic [4:0] change;
    logic       coin_reject;
    logic       sale_refused;

    modport master (
        output mode, coin_valid, coin, sel_valid, sel, cancel,
               dispense_ack, change_ack, retrieve,
        input  machineAcc, credit, dispense, item, change_valid, change,
               coin_reject, sale_refused
    );

    modport slave (
        input  mode, coin_valid, coin, sel_valid, sel, cancel,
               dispense_ack, change_ack, retrieve,
        output machineAcc, credit, dispense, item, change_valid, change,
               coin_reject, sale_refused
    );
endinterface

// File: rtl/customer_deposit.sv
// customer_deposit: coin credit collection, price check, sale accounting
// into the machine accumulator and change payout via two-phase handshake.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  customer_deposit_if.slave (see interface file for signal list)
// All outputs come straight from registers.
module customer_deposit #(
    parameter logic [4:0] PRICE0     = 5'd3,
    parameter logic [4:0] PRICE1     = 5'd5,
    parameter logic [4:0] PRICE2     = 5'd7,
    parameter logic [4:0] PRICE3     = 5'd12,
    parameter logic [4:0] MAX_CREDIT = 5'd31,
    parameter logic [4:0] ACC_MAX    = 5'd31
) (
    input logic               clk,
    input logic               rst,
    customer_deposit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t     state, state_n;
    logic [4:0] acc, acc_n, credit, credit_n, change, change_n;
    logic [1:0] item, item_n;
    logic       disp, disp_n, cv, cv_n, crej, crej_n, sref, sref_n;

    // 6-bit arithmetic so sums and differences never wrap before compare
    logic [5:0] coin_val, price, credit_sum, acc_sum, credit_diff;

    always_comb begin
        case (bus.coin)
            2'b00:   coin_val = 6'd1;
            2'b01:   coin_val = 6'd2;
            2'b10:   coin_val = 6'd5;
            default: coin_val = 6'd10;
        endcase
    end

    always_comb begin
        case (bus.sel)
            2'd0:    price = {1'b0, PRICE0};
            2'd1:    price = {1'b0, PRICE1};
            2'd2:    price = {1'b0, PRICE2};
            default: price = {1'b0, PRICE3};
        endcase
    end

    assign credit_sum  = {1'b0, credit} + coin_val;
    assign acc_sum     = {1'b0, acc} + price;
    assign credit_diff = {1'b0, credit} - price;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            credit <= '0;
            change <= '0;
            item   <= '0;
            disp   <= 1'b0;
            cv     <= 1'b0;
            crej   <= 1'b0;
            sref   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            credit <= credit_n;
            change <= change_n;
            item   <= item_n;
            disp   <= disp_n;
            cv     <= cv_n;
            crej   <= crej_n;
            sref   <= sref_n;
        end
    end

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        credit_n = credit;
        change_n = change;
        item_n   = item;
        disp_n   = disp;
        cv_n     = cv;
        crej_n   = 1'b0;
        sref_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mode) begin
                    crej_n = bus.coin_valid;
                    sref_n = bus.sel_valid;
                    if (bus.retrieve) acc_n = '0;
                end else if (bus.coin_valid) begin
                    if (coin_val > {1'b0, MAX_CREDIT}) begin
                        crej_n = 1'b1;
                    end else begin
                        credit_n = credit_sum[4:0];
                        state_n  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                // mode is deliberately not looked at: a started sale finishes
                if (bus.cancel) begin
                    crej_n   = bus.coin_valid;
                    change_n = credit;
                    credit_n = '0;
                    cv_n     = 1'b1;
                    state_n  = CHANGE;
                end else if (bus.sel_valid) begin
                    crej_n = bus.coin_valid;
                    if (({1'b0, credit} < price) || (acc_sum > {1'b0, ACC_MAX})) begin
                        sref_n = 1'b1;
                    end else begin
                        acc_n    = acc_sum[4:0];
                        change_n = credit_diff[4:0];
                        credit_n = '0;
                        item_n   = bus.sel;
                        disp_n   = 1'b1;
                        state_n  = VEND;
                    end
                end else if (bus.coin_valid) begin
                    if (credit_sum > {1'b0, MAX_CREDIT}) crej_n = 1'b1;
                    else                                 credit_n = credit_sum[4:0];
                end
            end
            VEND: begin
                crej_n = bus.coin_valid;
                if (bus.dispense_ack) begin
                    disp_n = 1'b0;
                    if (change != '0) begin
                        cv_n    = 1'b1;
                        state_n = CHANGE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin // CHANGE
                crej_n = bus.coin_valid;
                if (bus.change_ack) begin
                    cv_n     = 1'b0;
                    change_n = '0;
                    state_n  = IDLE;
                end
            end
        endcase
    end

    assign bus.machineAcc   = acc;
    assign bus.credit       = credit;
    assign bus.dispense     = disp;
    assign bus.item         = item;
    assign bus.change_valid = cv;
    assign bus.change       = change;
    assign bus.coin_reject  = crej;
    assign bus.sale_refused = sref;
endmodule

// File: tb/tb_customer_deposit.sv
// tb_customer_deposit: scoreboard bench for customer_deposit.
// Each step drives one cycle of stimulus and queues the hand-derived
// outputs expected after that edge; the queue is drained and compared
// field by field once the edge has passed.
module tb_customer_deposit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    customer_deposit_if bus();

    customer_deposit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic [4:0] cr;
        logic [4:0] acc;
        logic       d;
        logic [1:0] it;
        logic       cv;
        logic [4:0] ch;
        logic       rj;
        logic       rf;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, want);
        end
    endtask

    task automatic clr();
        bus.coin_valid   = 1'b0;
        bus.coin         = 2'b00;
        bus.sel_valid    = 1'b0;
        bus.sel          = 2'd0;
        bus.cancel       = 1'b0;
        bus.dispense_ack = 1'b0;
        bus.change_ack   = 1'b0;
        bus.retrieve     = 1'b0;
        rst              = 1'b0;
    endtask

    // one clock: queue expectation, take the edge, then compare
    task automatic go(input string tag, input int cr, input int acc, input int d,
                      input int it, input int cv, input int ch, input int rj, input int rf);
        exp_t e;
        e.tag = tag;
        e.cr = 5'(cr); e.acc = 5'(acc); e.d = 1'(d); e.it = 2'(it);
        e.cv = 1'(cv); e.ch = 5'(ch); e.rj = 1'(rj); e.rf = 1'(rf);
        sb.push_back(e);
        @(posedge clk);
        #1;
        clr();
        if (sb.size() == 0) begin
            chk({tag, ".queue"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".credit"},       8'(bus.credit),       8'(e.cr));
            chk({e.tag, ".machineAcc"},   8'(bus.machineAcc),   8'(e.acc));
            chk({e.tag, ".dispense"},     8'(bus.dispense),     8'(e.d));
            chk({e.tag, ".item"},         8'(bus.item),         8'(e.it));
            chk({e.tag, ".change_valid"}, 8'(bus.change_valid), 8'(e.cv));
            chk({e.tag, ".change"},       8'(bus.change),       8'(e.ch));
            chk({e.tag, ".coin_reject"},  8'(bus.coin_reject),  8'(e.rj));
            chk({e.tag, ".sale_refused"}, 8'(bus.sale_refused), 8'(e.rf));
        end
    endtask

    task automatic coin(input logic [1:0] c);
        bus.coin_valid = 1'b1;
        bus.coin       = c;
    endtask

    task automatic pick(input logic [1:0] s);
        bus.sel_valid = 1'b1;
        bus.sel       = s;
    endtask

    initial begin
        bus.mode = 1'b0;
        clr();
        rst = 1'b1;
        go("reset", 0,0,0,0,0,0,0,0);

        // 5 + 2, buy item 1, change 2
        coin(2'b10);               go("t1c5",   5,0,0,0,0,0,0,0);
        coin(2'b01);               go("t1c2",   7,0,0,0,0,0,0,0);
        pick(2'd1);                go("t1sel",  0,5,1,1,0,2,0,0);
                                   go("t1hold", 0,5,1,1,0,2,0,0);
        bus.dispense_ack = 1'b1;   go("t1dack", 0,5,0,1,1,2,0,0);
                                   go("t1chg",  0,5,0,1,1,2,0,0);
        bus.change_ack = 1'b1;     go("t1cack", 0,5,0,1,0,0,0,0);

        // 10 + 2, buy item 3, no change
        coin(2'b11);               go("t2c10",  10,5,0,1,0,0,0,0);
        coin(2'b01);               go("t2c2",   12,5,0,1,0,0,0,0);
        pick(2'd3);                go("t2sel",  0,17,1,3,0,0,0,0);
        coin(2'b00); pick(2'd0);   go("t2vcoin",0,17,1,3,0,0,1,0);
        bus.dispense_ack = 1'b1;   go("t2dack", 0,17,0,3,0,0,0,0);
        coin(2'b00);               go("t2idle", 1,17,0,3,0,0,0,0);
        bus.cancel = 1'b1;         go("t2can",  0,17,0,3,1,1,0,0);
        bus.change_ack = 1'b1;     go("t2cack", 0,17,0,3,0,0,0,0);

        // credit ceiling
        coin(2'b11);               go("t3c10a", 10,17,0,3,0,0,0,0);
        coin(2'b11);               go("t3c10b", 20,17,0,3,0,0,0,0);
        coin(2'b11);               go("t3c10c", 30,17,0,3,0,0,0,0);
        coin(2'b01);               go("t3over", 30,17,0,3,0,0,1,0);
        coin(2'b00);               go("t3max",  31,17,0,3,0,0,0,0);
        coin(2'b00); bus.cancel=1; go("t3can",  0,17,0,3,1,31,1,0);
        coin(2'b10);               go("t3chgc", 0,17,0,3,1,31,1,0);
        bus.change_ack = 1'b1;     go("t3cack", 0,17,0,3,0,0,0,0);

        // refused for low credit, coin alongside selection
        coin(2'b01);               go("t4c2",   2,17,0,3,0,0,0,0);
        pick(2'd0);                go("t4ref",  2,17,0,3,0,0,0,1);
        pick(2'd0); coin(2'b00);   go("t4both", 2,17,0,3,0,0,1,1);
        bus.dispense_ack = 1'b1;   go("t4dack", 2,17,0,3,0,0,0,0);
        coin(2'b00);               go("t4c1",   3,17,0,3,0,0,0,0);
        pick(2'd0);                go("t4sel",  0,20,1,0,0,0,0,0);
        bus.dispense_ack = 1'b1;   go("t4done", 0,20,0,0,0,0,0,0);

        // accumulator ceiling, then owner drain
        coin(2'b10);               go("t5c5",   5,20,0,0,0,0,0,0);
        pick(2'd1);                go("t5s1",   0,25,1,1,0,0,0,0);
        bus.dispense_ack = 1'b1;   go("t5d1",   0,25,0,1,0,0,0,0);
        coin(2'b01);               go("t5c2",   2,25,0,1,0,0,0,0);
        coin(2'b00);               go("t5c1",   3,25,0,1,0,0,0,0);
        pick(2'd0);                go("t5s0",   0,28,1,0,0,0,0,0);
        bus.dispense_ack = 1'b1;   go("t5d0",   0,28,0,0,0,0,0,0);
        coin(2'b10);               go("t5c5b",  5,28,0,0,0,0,0,0);
        pick(2'd1);                go("t5accref",5,28,0,0,0,0,0,1);
        pick(2'd0);                go("t5accmax",0,31,1,0,0,2,0,0);
        bus.dispense_ack = 1'b1;   go("t5dack", 0,31,0,0,1,2,0,0);
        bus.change_ack = 1'b1;     go("t5cack", 0,31,0,0,0,0,0,0);
        bus.mode = 1'b1;
        bus.retrieve = 1'b1;       go("t5retr", 0,0,0,0,0,0,0,0);
        coin(2'b10);               go("t5ocoin",0,0,0,0,0,0,1,0);
        pick(2'd2);                go("t5osel", 0,0,0,0,0,0,0,1);
        bus.mode = 1'b0;

        // mode ignored mid-transaction; reset during CHANGE
        coin(2'b10);               go("t6c5",   5,0,0,0,0,0,0,0);
        bus.mode = 1'b1; coin(2'b01); go("t6mode", 7,0,0,0,0,0,0,0);
        bus.mode = 1'b0;
        pick(2'd0);                go("t6sel",  0,3,1,0,0,4,0,0);
        bus.dispense_ack = 1'b1;   go("t6dack", 0,3,0,0,1,4,0,0);
        rst = 1'b1; bus.change_ack = 1'b1; go("t6rst", 0,0,0,0,0,0,0,0);
        bus.change_ack = 1'b1;     go("t6cack", 0,0,0,0,0,0,0,0);
        coin(2'b00);               go("t6idle", 1,0,0,0,0,0,0,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
